// File: rtl/vend_pkg.sv
// Shared types and defaults for the coin-credit vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } vend_state_t;

  localparam int unsigned DEF_COIN_LO      = 5;
  localparam int unsigned DEF_COIN_HI      = 10;
  localparam int unsigned DEF_PRICE_COFFEE = 15;
  localparam int unsigned DEF_PRICE_TEA    = 10;
  localparam int unsigned DEF_MAX_CREDIT   = 30;

  // Value of the coins presented in one cycle; both may arrive together.
  function automatic int unsigned coin_value(input logic lo, input logic hi,
                                             input int unsigned lo_val,
                                             input int unsigned hi_val);
    return (lo ? lo_val : 0) + (hi ? hi_val : 0);
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Pays out change one coin per cycle, largest coin first.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned COIN_LO  = DEF_COIN_LO,
  parameter int unsigned COIN_HI  = DEF_COIN_HI
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_value,
  input  logic                step,
  output logic                chg_hi,
  output logic                chg_lo,
  output logic                done
);

  localparam logic [CREDIT_W-1:0] LO_V = COIN_LO[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] HI_V = COIN_HI[CREDIT_W-1:0];

  logic [CREDIT_W-1:0] remaining;
  logic [CREDIT_W-1:0] src;
  logic                fire;
  logic                use_hi;

  // A load pays its first coin immediately, so change starts the cycle it is loaded.
  always_comb begin
    src    = load ? load_value : remaining;
    fire   = load | step;
    use_hi = (src >= HI_V);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      chg_hi    <= 1'b0;
      chg_lo    <= 1'b0;
    end else begin
      chg_hi <= fire & use_hi;
      chg_lo <= fire & ~use_hi;
      if (fire) begin
        remaining <= src - (use_hi ? HI_V : LO_V);
      end
    end
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/vend_controller.sv
// Coin-credit vending controller: credit accumulation, product selection and change return.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W     = 6,
  parameter int unsigned COIN_LO      = DEF_COIN_LO,
  parameter int unsigned COIN_HI      = DEF_COIN_HI,
  parameter int unsigned PRICE_COFFEE = DEF_PRICE_COFFEE,
  parameter int unsigned PRICE_TEA    = DEF_PRICE_TEA,
  parameter int unsigned MAX_CREDIT   = DEF_MAX_CREDIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_lo,
  input  logic                coin_hi,
  input  logic                sel_coffee,
  input  logic                sel_tea,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                disp_coffee,
  output logic                disp_tea,
  output logic                chg_lo,
  output logic                chg_hi,
  output logic                coin_reject,
  output logic                short_credit
);

  if (COIN_HI % COIN_LO != 0) begin : g_bad_coin_hi
    $error("COIN_HI must be a multiple of COIN_LO");
  end
  if ((PRICE_COFFEE % COIN_LO != 0) || (PRICE_COFFEE > MAX_CREDIT)) begin : g_bad_coffee
    $error("PRICE_COFFEE must be a multiple of COIN_LO and at most MAX_CREDIT");
  end
  if ((PRICE_TEA % COIN_LO != 0) || (PRICE_TEA > MAX_CREDIT)) begin : g_bad_tea
    $error("PRICE_TEA must be a multiple of COIN_LO and at most MAX_CREDIT");
  end
  if (MAX_CREDIT >= (2 ** CREDIT_W)) begin : g_bad_max
    $error("MAX_CREDIT must fit in CREDIT_W bits");
  end

  localparam int unsigned SUM_W = CREDIT_W + 2;
  localparam logic [SUM_W-1:0]    MAX_V    = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] COFFEE_V = CREDIT_W'(PRICE_COFFEE);
  localparam logic [CREDIT_W-1:0] TEA_V    = CREDIT_W'(PRICE_TEA);

  vend_state_t         state, state_next;
  logic [CREDIT_W-1:0] credit_next, credit_after, load_value;
  logic [SUM_W-1:0]    sum, total;
  logic                coin_any, load, step, done;
  logic                busy_next, disp_coffee_next, disp_tea_next;
  logic                reject_next, short_next;

  vend_change_unit #(
    .CREDIT_W(CREDIT_W),
    .COIN_LO (COIN_LO),
    .COIN_HI (COIN_HI)
  ) u_change (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(load_value),
    .step      (step),
    .chg_hi    (chg_hi),
    .chg_lo    (chg_lo),
    .done      (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      busy         <= 1'b0;
      disp_coffee  <= 1'b0;
      disp_tea     <= 1'b0;
      coin_reject  <= 1'b0;
      short_credit <= 1'b0;
    end else begin
      state        <= state_next;
      credit       <= credit_next;
      busy         <= busy_next;
      disp_coffee  <= disp_coffee_next;
      disp_tea     <= disp_tea_next;
      coin_reject  <= reject_next;
      short_credit <= short_next;
    end
  end

  // Coins are settled first; the selection then sees the updated credit.
  always_comb begin
    state_next       = state;
    credit_next      = credit;
    credit_after     = credit;
    disp_coffee_next = 1'b0;
    disp_tea_next    = 1'b0;
    reject_next      = 1'b0;
    short_next       = 1'b0;
    load             = 1'b0;
    load_value       = credit;
    step             = 1'b0;
    coin_any         = coin_lo | coin_hi;
    sum              = SUM_W'(coin_value(coin_lo, coin_hi, COIN_LO, COIN_HI));
    total            = SUM_W'(credit) + sum;

    case (state)
      IDLE: begin
        if (coin_any) begin
          if (total <= MAX_V) credit_after = total[CREDIT_W-1:0];
          else                reject_next  = 1'b1;
        end
        credit_next = credit_after;
        if (cancel) begin
          if (credit_after != '0) begin
            load        = 1'b1;
            load_value  = credit_after;
            credit_next = '0;
            state_next  = CHANGE;
          end
        end else if (sel_coffee) begin
          if (credit_after >= COFFEE_V) begin
            credit_next      = credit_after - COFFEE_V;
            disp_coffee_next = 1'b1;
            state_next       = VEND;
          end else begin
            short_next = 1'b1;
          end
        end else if (sel_tea) begin
          if (credit_after >= TEA_V) begin
            credit_next   = credit_after - TEA_V;
            disp_tea_next = 1'b1;
            state_next    = VEND;
          end else begin
            short_next = 1'b1;
          end
        end
      end
      VEND: begin
        reject_next = coin_any;
        if (credit != '0) begin
          load        = 1'b1;
          credit_next = '0;
          state_next  = CHANGE;
        end else begin
          state_next = IDLE;
        end
      end
      CHANGE: begin
        reject_next = coin_any;
        if (done) state_next = IDLE;
        else      step       = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
